// File: rtl/baccarat_pkg.sv
// Shared types and constants for the Baccarat hand sequencer.
// The optional single-step build is selected by defining STEP_EN (see baccarat_sequencer).
package baccarat_pkg;

    localparam int CARD_W = 4;

    typedef enum logic [3:0] {
        S_RESET,
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EVAL,
        S_P3,
        S_EVALB,
        S_D3,
        S_DONE
    } state_t;

    localparam logic [CARD_W-1:0] CARD_TEN         = 4'd10;
    localparam logic [CARD_W-1:0] NATURAL_MIN      = 4'd8;
    localparam logic [CARD_W-1:0] PLAYER_STAND_MIN = 4'd6;

    // Face cards, tens and illegal codes all count as zero points.
    function automatic logic [CARD_W-1:0] card_value(input logic [CARD_W-1:0] code);
        if ((code != '0) && (code < CARD_TEN)) begin
            return code;
        end
        return '0;
    endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card decision once the player has drawn: (dealer score, player third-card value) -> draw.
module dealer_draw_rule
    import baccarat_pkg::*;
(
    input  logic [CARD_W-1:0] dscore,
    input  logic [CARD_W-1:0] v,
    output logic              draw
);

    // Scores of 7 and above (including illegal 10..15) stand.
    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// Baccarat game controller: deals one hand per reset, applies third-card rules, drives win lights.
// Optional build macro STEP_EN adds a 'step' input that gates every state advance and load pulse.
module baccarat_sequencer
    import baccarat_pkg::*;
(
    input  logic              slow_clock,
    input  logic              resetb,
`ifdef STEP_EN
    input  logic              step,
`endif
    input  logic [CARD_W-1:0] pcard3,
    input  logic [CARD_W-1:0] pscore,
    input  logic [CARD_W-1:0] dscore,
    output logic              load_pcard1,
    output logic              load_pcard2,
    output logic              load_pcard3,
    output logic              load_dcard1,
    output logic              load_dcard2,
    output logic              load_dcard3,
    output logic              player_win_light,
    output logic              dealer_win_light,
    output logic              game_over
);

    state_t state_q;
    state_t state_d;
    logic   advance;
    logic   dealerDraws;

`ifdef STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    dealer_draw_rule u_dealer_draw_rule (
        .dscore (dscore),
        .v      (card_value(pcard3)),
        .draw   (dealerDraws)
    );

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (advance) begin
            case (state_q)
                S_RESET: state_d = S_P1;
                S_P1:    state_d = S_D1;
                S_D1:    state_d = S_P2;
                S_P2:    state_d = S_D2;
                S_D2:    state_d = S_EVAL;
                // Illegal scores >= 10 fall into the natural branch.
                S_EVAL: begin
                    if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                        state_d = S_DONE;
                    end else if (pscore < PLAYER_STAND_MIN) begin
                        state_d = S_P3;
                    end else if (dscore < PLAYER_STAND_MIN) begin
                        state_d = S_D3;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_P3:    state_d = S_EVALB;
                S_EVALB: state_d = dealerDraws ? S_D3 : S_DONE;
                S_D3:    state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_RESET;
            endcase
        end
    end

    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        game_over        = 1'b0;
        case (state_q)
            S_P1:   load_pcard1 = advance;
            S_D1:   load_dcard1 = advance;
            S_P2:   load_pcard2 = advance;
            S_D2:   load_dcard2 = advance;
            S_P3:   load_pcard3 = advance;
            S_D3:   load_dcard3 = advance;
            S_DONE: begin
                game_over        = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Self-checking bench for baccarat_sequencer: directed hands, full dealer-rule sweep, random hands,
// mid-deal reset, and (when built with STEP_EN) single-step gating.
module tb_baccarat_sequencer;

    logic       slowClock = 1'b0;
    logic       resetb;
`ifdef STEP_EN
    logic       step;
`endif
    logic [3:0] pcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic       loadP1, loadP2, loadP3, loadD1, loadD2, loadD3;
    logic       playerWin, dealerWin, gameOver;

    int checkCount = 0;
    int failCount  = 0;

    baccarat_sequencer dut (
        .slow_clock       (slowClock),
        .resetb           (resetb),
`ifdef STEP_EN
        .step             (step),
`endif
        .pcard3           (pcard3),
        .pscore           (pscore),
        .dscore           (dscore),
        .load_pcard1      (loadP1),
        .load_pcard2      (loadP2),
        .load_pcard3      (loadP3),
        .load_dcard1      (loadD1),
        .load_dcard2      (loadD2),
        .load_dcard3      (loadD3),
        .player_win_light (playerWin),
        .dealer_win_light (dealerWin),
        .game_over        (gameOver)
    );

    always #5 slowClock = ~slowClock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Load vector packed as {d3,d2,d1,p3,p2,p1}.
    function automatic logic [5:0] loadsNow();
        return {loadD3, loadD2, loadD1, loadP3, loadP2, loadP1};
    endfunction

    // Baccarat tableau: bit v of the mask is set when the dealer draws against player third-card value v.
    function automatic bit modelDealerDraws(int d, int c3);
        int        v;
        bit [9:0]  mask;
        v = (c3 >= 1 && c3 <= 9) ? c3 : 0;
        case (d)
            0, 1, 2: mask = 10'h3FF;
            3:       mask = 10'h2FF;
            4:       mask = 10'h0FC;
            5:       mask = 10'h0F0;
            6:       mask = 10'h0C0;
            default: mask = 10'h000;
        endcase
        return mask[v];
    endfunction

    // Plays one hand from reset; the model lists which load is expected on each cycle after release.
    task automatic applyStimulus(input int p, input int d, input int c3, input int pf, input int df);
        logic [5:0] expLoads [1:12];
        int         doneCycle;
        for (int k = 1; k <= 12; k++) expLoads[k] = 6'b0;
        expLoads[1] = 6'b000001;
        expLoads[2] = 6'b001000;
        expLoads[3] = 6'b000010;
        expLoads[4] = 6'b010000;
        if (p >= 8 || d >= 8) begin
            doneCycle = 6;
        end else if (p <= 5) begin
            expLoads[6] = 6'b000100;
            if (modelDealerDraws(d, c3)) begin
                expLoads[8] = 6'b100000;
                doneCycle = 9;
            end else begin
                doneCycle = 8;
            end
        end else if (d <= 5) begin
            expLoads[6] = 6'b100000;
            doneCycle = 7;
        end else begin
            doneCycle = 6;
        end

        resetb = 1'b0;
        pscore = 4'(p);
        dscore = 4'(d);
        pcard3 = 4'(c3);
        @(posedge slowClock); #1;
        checkOutput("reset_loads", 32'(loadsNow()), 32'd0);
        checkOutput("reset_flags", {29'd0, playerWin, dealerWin, gameOver}, 32'd0);
        resetb = 1'b1;
        for (int k = 1; k <= doneCycle + 1; k++) begin
            @(posedge slowClock); #1;
            if (k >= doneCycle) begin
                pscore = 4'(pf);
                dscore = 4'(df);
            end
            #1;
            checkOutput($sformatf("loads p%0d d%0d c%0d cyc%0d", p, d, c3, k), 32'(loadsNow()), 32'(expLoads[k]));
            checkOutput($sformatf("game_over cyc%0d", k), 32'(gameOver), 32'(k >= doneCycle));
            checkOutput($sformatf("lights cyc%0d", k), {30'd0, playerWin, dealerWin},
                        (k >= doneCycle) ? {30'd0, pf >= df, df >= pf} : 32'd0);
        end
    endtask

    initial begin
        resetb = 1'b0;
        pcard3 = '0;
        pscore = '0;
        dscore = '0;
`ifdef STEP_EN
        step   = 1'b1;
`endif
        @(posedge slowClock); #1;

        // Directed hands: natural, player draws / dealer stands, player stands / dealer draws.
        applyStimulus(8, 3, 5, 8, 3);
        applyStimulus(3, 4, 13, 3, 4);
        applyStimulus(6, 3, 0, 6, 6);
        applyStimulus(7, 7, 4, 7, 7);
        applyStimulus(10, 2, 1, 9, 2);

        // Dealer rule sweep with the player always drawing.
        for (int d = 0; d <= 7; d++) begin
            for (int c = 1; c <= 13; c++) begin
                applyStimulus(0, d, c, $urandom_range(9), d);
            end
        end

        // Random hands, occasionally with illegal scores and card codes.
        for (int n = 0; n < 150; n++) begin
            applyStimulus($urandom_range(11), $urandom_range(11), $urandom_range(15),
                          $urandom_range(9), $urandom_range(9));
        end

        // Reset sampled while in S_P2 aborts the hand.
        resetb = 1'b0;
        @(posedge slowClock); #1;
        resetb = 1'b1;
        pscore = 4'd2;
        dscore = 4'd2;
        repeat (3) @(posedge slowClock);
        #1;
        checkOutput("midreset_in_p2", 32'(loadsNow()), 32'b000010);
        resetb = 1'b0;
        @(posedge slowClock); #1;
        checkOutput("midreset_loads", 32'(loadsNow()), 32'd0);
        checkOutput("midreset_flags", {29'd0, playerWin, dealerWin, gameOver}, 32'd0);
        resetb = 1'b1;
        @(posedge slowClock); #1;
        checkOutput("restart_pcard1", 32'(loadsNow()), 32'b000001);

`ifdef STEP_EN
        // Hold in S_D1 with step low, then release a single step.
        resetb = 1'b0;
        @(posedge slowClock); #1;
        resetb = 1'b1;
        repeat (2) @(posedge slowClock);
        #1;
        step = 1'b0;
        #1;
        checkOutput("step_hold_d1_initial", 32'(loadsNow()), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge slowClock); #1;
            checkOutput($sformatf("step_hold_%0d", k), 32'(loadsNow()), 32'd0);
        end
        step = 1'b1;
        #1;
        checkOutput("step_load_dcard1", 32'(loadsNow()), 32'b001000);
        @(posedge slowClock); #1;
        checkOutput("step_advance_p2", 32'(loadsNow()), 32'b000010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
